parity_gen_chk: RTL and testbench
=================================

Name: parity_gen_chk

Overview:
Parametrised, clocked parity generator/checker. It is the successor to the combinational 4-input parity generator.
- Parallel path: registered parity over a DATA_W-bit word, selectable even/odd, in generate or check mode.
- Serial path: bit-stream frame parity accumulated by a small FSM.
- Both paths feed one error flag, a sticky error flag and a saturating error counter. The error outputs are read by the top-level status logic.

Parameters:
DATA_W, 4, width of parallel data word (>=2)
CNT_W, 8, width of saturating error counter (>=2)
ODD_PAR, 0, 0 = even parity (parity bit makes total ones even), 1 = odd parity

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = generate, 1 = check; sampled with in_valid / ser_valid
in_valid  in  1  parallel word valid
in_data  in  DATA_W  parallel data word
in_par  in  1  received parity bit (check mode only)
ser_valid  in  1  serial bit valid
ser_bit  in  1  serial data bit
ser_last  in  1  marks final bit of frame; qualified by ser_valid
clr_err  in  1  synchronous clear of err_sticky and err_cnt
out_valid  out  1  parallel result valid
out_data  out  DATA_W  registered copy of in_data
out_par  out  1  generated parity bit (both modes)
ser_done  out  1  one-cycle pulse, frame parity ready
ser_par  out  1  frame parity, held until next ser_done
err  out  1  one-cycle pulse on any check failure
err_sticky  out  1  set on any err, held until clr_err
err_cnt  out  CNT_W  saturating count of errors

Behaviour:
- Reset: asynchronous, active-low. All outputs are 0, err_cnt is 0 and the FSM is in IDLE.
- Parity function: p = ^in_data ^ ODD_PAR.
- Parallel path, latency 1 cycle:
  - When in_valid=1, the next edge sets out_valid=1, out_data=in_data and out_par=p.
  - When in_valid=0, out_valid=0 and out_data/out_par hold their values.
  - Check mode (mode=1): a mismatch (in_par != p) asserts err in the same cycle as out_valid.
- Serial FSM, states IDLE, ACCUM:
  - IDLE, ser_valid=1, ser_last=0: acc <= ser_bit, go to ACCUM.
  - IDLE, ser_valid=1, ser_last=1: single-bit frame. ser_par <= ser_bit ^ ODD_PAR, ser_done=1, stay in IDLE.
  - ACCUM, ser_valid=1: acc <= acc ^ ser_bit.
  - ACCUM, ser_valid=1, ser_last=1: ser_par <= acc ^ ser_bit ^ ODD_PAR, ser_done=1 next cycle, return to IDLE.
  - ser_valid=0: state and acc hold.
  - Serial frames are generate-only and never raise err.
- err: pulse lasting exactly 1 cycle per failing parallel word. Back-to-back failing words produce err high on consecutive cycles.
- err_sticky: set when err=1, cleared only by clr_err or reset.
- err_cnt: increments by 1 per err and saturates at 2^CNT_W-1 (no wrap).
- Simultaneous clr_err and err in the same cycle: clr wins. Result is err_cnt=0, err_sticky=0, and the error pulse is still emitted on err.
- Reset mid-frame: FSM returns to IDLE, the accumulator is discarded and no ser_done is emitted.
- The parallel and serial paths are fully independent and may be active in the same cycle.

Optional Feature:
Macro PARITY_PIPE2_EN.
- Defined: the parallel path gains a second register stage. out_valid, out_data, out_par and err have latency 2. in_valid may still be asserted every cycle (full throughput). The serial path is unchanged.
- Undefined: latency 1 as described above.

Test Plan:
- Reset, exhaustive generate: DATA_W=4, ODD_PAR=0, mode=0, in_data swept 0..15 one per cycle. out_par = popcount parity, 1 cycle later each (e.g. 4'b0111 -> 1, 4'b0110 -> 0), and err stays 0.
- Check mode with corrupted parity: in_data=4'b1011, in_par=0 (correct is 1). err pulses once, err_sticky=1, err_cnt=1. in_par=1 -> no err.
- Saturation and clear: CNT_W=2, 5 consecutive bad words. err_cnt goes 1,2,3,3,3. Then clr_err together with a bad word -> err_cnt=0, err_sticky=0, err=1 that cycle.
- Serial frame: bits 1,0,1,1,1 with ser_last on the 5th bit, ODD_PAR=0. ser_done pulses 1 cycle after the last bit, ser_par=0. Single-bit frame ser_bit=1 with ser_last -> ser_par=1.
- Reset mid-frame: 3 bits sent, then rst_n low for 2 cycles, then a new 2-bit frame 1,1. ser_par=0 and no spurious ser_done.
- With PARITY_PIPE2_EN: repeat the exhaustive sweep with in_valid continuous. Results match case 1, delayed by 2 cycles, with no gaps in out_valid.

Source files
------------

// File: rtl/parity_if.sv
// Bus bundle for parity_gen_chk: parallel word, serial bit stream and error status.
// The master drives the data/control inputs; the slave (the parity block) drives results.
interface parity_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) ();
    logic              mode;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_par;
    logic              ser_valid;
    logic              ser_bit;
    logic              ser_last;
    logic              clr_err;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_par;
    logic              ser_done;
    logic              ser_par;
    logic              err;
    logic              err_sticky;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output mode, in_valid, in_data, in_par, ser_valid, ser_bit, ser_last, clr_err,
        input  out_valid, out_data, out_par, ser_done, ser_par, err, err_sticky, err_cnt
    );

    modport slave (
        input  mode, in_valid, in_data, in_par, ser_valid, ser_bit, ser_last, clr_err,
        output out_valid, out_data, out_par, ser_done, ser_par, err, err_sticky, err_cnt
    );
endinterface

// File: rtl/parity_gen_chk.sv
// Clocked parity generator/checker: registered parallel path, serial frame-parity FSM and
// shared error pulse/sticky/saturating counter. Define PARITY_PIPE2_EN for a 2-stage parallel path.
module parity_gen_chk #(
    parameter int DATA_W  = 4,
    parameter int CNT_W   = 8,
    parameter int ODD_PAR = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    parity_if.slave  bus
);
    localparam logic             ODD_BIT = (ODD_PAR != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_IDLE, S_ACCUM} ser_state_t;

    function automatic logic word_parity(input logic [DATA_W-1:0] d);
        return (^d) ^ ODD_BIT;
    endfunction

    logic              word_par;
    logic              vld_p1_q, vld_p1_d;
    logic [DATA_W-1:0] data_p1_q, data_p1_d;
    logic              par_p1_q, par_p1_d;
    logic              err_p1_q, err_p1_d;
    logic              err_evt;
    logic              sticky_q, sticky_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    ser_state_t        state_q, state_d;
    logic              acc_q, acc_d;
    logic              ser_par_q, ser_par_d;
    logic              ser_done_q, ser_done_d;

    // Stage p1: register the word, its parity and the check result
    always_comb begin
        word_par  = word_parity(bus.in_data);
        vld_p1_d  = bus.in_valid;
        data_p1_d = bus.in_valid ? bus.in_data : data_p1_q;
        par_p1_d  = bus.in_valid ? word_par : par_p1_q;
        err_p1_d  = bus.in_valid & bus.mode & (bus.in_par != word_par);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            data_p1_q <= '0;
            par_p1_q  <= 1'b0;
            err_p1_q  <= 1'b0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            data_p1_q <= data_p1_d;
            par_p1_q  <= par_p1_d;
            err_p1_q  <= err_p1_d;
        end
    end

`ifdef PARITY_PIPE2_EN
    logic              vld_p2_q, vld_p2_d;
    logic [DATA_W-1:0] data_p2_q, data_p2_d;
    logic              par_p2_q, par_p2_d;
    logic              err_p2_q, err_p2_d;

    // Stage p2: extra register for timing; holds like p1 when no word advances
    always_comb begin
        vld_p2_d  = vld_p1_q;
        data_p2_d = vld_p1_q ? data_p1_q : data_p2_q;
        par_p2_d  = vld_p1_q ? par_p1_q : par_p2_q;
        err_p2_d  = err_p1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            par_p2_q  <= 1'b0;
            err_p2_q  <= 1'b0;
        end else begin
            vld_p2_q  <= vld_p2_d;
            data_p2_q <= data_p2_d;
            par_p2_q  <= par_p2_d;
            err_p2_q  <= err_p2_d;
        end
    end

    assign err_evt       = err_p2_d;
    assign bus.out_valid = vld_p2_q;
    assign bus.out_data  = data_p2_q;
    assign bus.out_par   = par_p2_q;
    assign bus.err       = err_p2_q;
`else
    assign err_evt       = err_p1_d;
    assign bus.out_valid = vld_p1_q;
    assign bus.out_data  = data_p1_q;
    assign bus.out_par   = par_p1_q;
    assign bus.err       = err_p1_q;
`endif

    // Status updates on the same edge that raises err, so clr_err can win against it
    always_comb begin
        sticky_d = sticky_q | err_evt;
        cnt_d    = (err_evt && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
        if (bus.clr_err) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        ser_par_d  = ser_par_q;
        ser_done_d = 1'b0;
        if (bus.ser_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.ser_last) begin
                        ser_par_d  = bus.ser_bit ^ ODD_BIT;
                        ser_done_d = 1'b1;
                    end else begin
                        acc_d   = bus.ser_bit;
                        state_d = S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc_d = acc_q ^ bus.ser_bit;
                    if (bus.ser_last) begin
                        ser_par_d  = acc_q ^ bus.ser_bit ^ ODD_BIT;
                        ser_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
            acc_q      <= 1'b0;
            ser_par_q  <= 1'b0;
            ser_done_q <= 1'b0;
        end else begin
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            acc_q      <= acc_d;
            ser_par_q  <= ser_par_d;
            ser_done_q <= ser_done_d;
        end
    end

    assign bus.err_sticky = sticky_q;
    assign bus.err_cnt    = cnt_q;
    assign bus.ser_done   = ser_done_q;
    assign bus.ser_par    = ser_par_q;
endmodule

// File: tb/tb_parity_gen_chk.sv
// Self-checking bench for parity_gen_chk (DATA_W=4, CNT_W=2, even parity): vector table plus
// scoreboard queues for the parallel and serial paths; follows PARITY_PIPE2_EN for latency.
module tb_parity_gen_chk;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 2;
`ifdef PARITY_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic       mode;
        logic [3:0] data;
        logic       par;
        logic       exp_par;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic       par;
        logic       err;
        logic       sticky;
        logic [1:0] cnt;
        int         cyc;
    } exp_t;

    typedef struct {
        logic par;
        int   cyc;
    } sexp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t  pq[$];
    sexp_t sq[$];
    exp_t  e;
    sexp_t se;
    vec_t  vt[24];
    logic [15:0] ptab;
    logic [1:0]  mcnt;
    logic        msticky;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    parity_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    parity_gen_chk #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ODD_PAR(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event (t=%0t)", name, $time);
    endtask

    // Monitor: compare every result the DUT produces against the scoreboards
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.out_valid === 1'b1) begin
                if (pq.size() == 0) flag("out_valid_unexpected");
                else begin
                    e = pq.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(e.data));
                    check("out_par", 32'(bus.out_par), 32'(e.par));
                    check("err", 32'(bus.err), 32'(e.err));
                    check("err_sticky", 32'(bus.err_sticky), 32'(e.sticky));
                    check("err_cnt", 32'(bus.err_cnt), 32'(e.cnt));
                    check("par_latency", 32'(cyc), 32'(e.cyc));
                end
            end else if (bus.err !== 1'b0) begin
                flag("err_without_out_valid");
            end
            if (bus.ser_done === 1'b1) begin
                if (sq.size() == 0) flag("ser_done_spurious");
                else begin
                    se = sq.pop_front();
                    check("ser_par", 32'(bus.ser_par), 32'(se.par));
                    check("ser_latency", 32'(cyc), 32'(se.cyc));
                end
            end
        end
    end

    task automatic drive_word(input vec_t v, input logic clr_with);
        exp_t x;
        if (v.exp_err) begin
            if (clr_with) begin
                mcnt    = 2'd0;
                msticky = 1'b0;
            end else begin
                if (mcnt != 2'd3) mcnt = mcnt + 2'd1;
                msticky = 1'b1;
            end
        end
        x = '{v.data, v.exp_par, v.exp_err, msticky, mcnt, cyc + LAT};
        pq.push_back(x);
        bus.mode     = v.mode;
        bus.in_valid = 1'b1;
        bus.in_data  = v.data;
        bus.in_par   = v.par;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [7:0] bits, input int n);
        logic acc = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.ser_valid = 1'b1;
            bus.ser_bit   = bits[i];
            bus.ser_last  = (i == n - 1);
            acc = acc ^ bits[i];
            if (i == n - 1) sq.push_back('{acc, cyc + 1});
            @(posedge clk); #1;
        end
        bus.ser_valid = 1'b0;
        bus.ser_last  = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (pq.size() == 0 && sq.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_par_queue", 32'(pq.size()), 32'd0);
        check("drain_ser_queue", 32'(sq.size()), 32'd0);
    endtask

    task automatic check_status(input string tag, input logic sticky, input logic [1:0] cnt);
        @(negedge clk);
        check({tag, "_sticky"}, 32'(bus.err_sticky), 32'(sticky));
        check({tag, "_cnt"}, 32'(bus.err_cnt), 32'(cnt));
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.mode      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_par    = 1'b0;
        bus.ser_valid = 1'b0;
        bus.ser_bit   = 1'b0;
        bus.ser_last  = 1'b0;
        bus.clr_err   = 1'b0;
        mcnt          = 2'd0;
        msticky       = 1'b0;

        // Bit i of ptab is the even parity of the 4-bit value i
        ptab = 16'h6996;
        for (int i = 0; i < 16; i++) vt[i] = '{1'b0, 4'(i), 1'b0, ptab[i], 1'b0};
        vt[16] = '{1'b1, 4'b1011, 1'b0, 1'b1, 1'b1};
        vt[17] = '{1'b1, 4'b1011, 1'b1, 1'b1, 1'b0};
        vt[18] = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b1};
        vt[19] = '{1'b1, 4'b1110, 1'b0, 1'b1, 1'b1};
        vt[20] = '{1'b1, 4'b0011, 1'b1, 1'b0, 1'b1};
        vt[21] = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b1};
        vt[22] = '{1'b1, 4'b1000, 1'b0, 1'b1, 1'b1};
        vt[23] = '{1'b1, 4'b0101, 1'b1, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_par", 32'(bus.out_par), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_err_sticky", 32'(bus.err_sticky), 32'd0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        check("rst_ser_done", 32'(bus.ser_done), 32'd0);
        check("rst_ser_par", 32'(bus.ser_par), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Exhaustive generate sweep with in_valid held high throughout
        for (int i = 0; i < 16; i++) drive_word(vt[i], 1'b0);
        bus.in_valid = 1'b0;
        drain();
        @(negedge clk);
        check("hold_out_data", 32'(bus.out_data), 32'hF);
        check("hold_out_par", 32'(bus.out_par), 32'd0);
        @(posedge clk); #1;
        check_status("sweep", 1'b0, 2'd0);

        // Check mode: corrupted then correct parity on 4'b1011
        drive_word(vt[16], 1'b0);
        bus.in_valid = 1'b0;
        drain();
        check_status("bad_word", 1'b1, 2'd1);
        drive_word(vt[17], 1'b0);
        bus.in_valid = 1'b0;
        drain();
        check_status("good_word", 1'b1, 2'd1);

        bus.clr_err = 1'b1;
        @(posedge clk); #1;
        bus.clr_err = 1'b0;
        mcnt    = 2'd0;
        msticky = 1'b0;
        check_status("clear", 1'b0, 2'd0);

        // Five back-to-back failing words saturate the 2-bit counter
        for (int i = 18; i < 23; i++) drive_word(vt[i], 1'b0);
        bus.in_valid = 1'b0;
        drain();
        check_status("saturate", 1'b1, 2'd3);

        // clr_err on the same edge that raises err: clear wins, pulse still seen
        if (LAT == 1) bus.clr_err = 1'b1;
        drive_word(vt[23], 1'b1);
        bus.in_valid = 1'b0;
        if (LAT == 2) begin
            bus.clr_err = 1'b1;
            @(posedge clk); #1;
        end
        bus.clr_err = 1'b0;
        drain();
        check_status("clr_vs_err", 1'b0, 2'd0);

        // Serial: 5-bit frame 1,0,1,1,1 then single-bit frame 1
        send_frame(8'b0001_1101, 5);
        drain();
        @(negedge clk);
        check("ser_par_hold0", 32'(bus.ser_par), 32'd0);
        @(posedge clk); #1;
        send_frame(8'b0000_0001, 1);
        drain();
        @(negedge clk);
        check("ser_par_hold1", 32'(bus.ser_par), 32'd1);
        @(posedge clk); #1;

        // Reset in the middle of a frame (1,0,0 sent), then a fresh frame 1,1
        bus.ser_valid = 1'b1;
        bus.ser_bit   = 1'b1;
        @(posedge clk); #1;
        bus.ser_bit   = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        bus.ser_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        mcnt    = 2'd0;
        msticky = 1'b0;
        @(negedge clk);
        check("midrst_ser_par", 32'(bus.ser_par), 32'd0);
        check("midrst_ser_done", 32'(bus.ser_done), 32'd0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        send_frame(8'b0000_0011, 2);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("final_par_queue", 32'(pq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
